// File: rtl/memory_copy_dma.sv
// Word-by-word memory copy initiator: one read then one write per word, ascending,
// on the single-cycle strobe/response bus, with an optional per-request timeout.
module memory_copy_dma #(
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LEN_WIDTH-1:0] words_done,
    output logic                 memory_read,
    output logic                 memory_write,
    output logic [31:0]          address,
    output logic [31:0]          write_data,
    input  logic [31:0]          read_data,
    input  logic                 response
);

    localparam int unsigned WaitWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned WaitLimit = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   words_done_q, words_done_d;
    logic                   error_q, error_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic [31:0]            address_q, address_d;
    logic [31:0]            write_data_q, write_data_d;
    logic [WaitWidth-1:0]   wait_cnt_q, wait_cnt_d;

    logic                   in_request;
    logic                   timeout_hit;
    logic [LEN_WIDTH-1:0]   words_inc;
    logic                   last_word;
    logic [31:0]            src_aligned;
    logic [31:0]            dst_aligned;

    assign in_request  = (state_q == StRead) || (state_q == StWrite);
    // Abort on the edge that would make the current request wait TIMEOUT_CYCLES cycles.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_request && !response &&
                         (wait_cnt_q == WaitWidth'(WaitLimit));
    assign words_inc   = words_done_q + LEN_WIDTH'(1);
    assign last_word   = (words_inc == len_q);
    assign src_aligned = {src_addr[31:2], 2'b00};
    assign dst_aligned = {dst_addr[31:2], 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            words_done_q <= words_done_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (len == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (timeout_hit) begin
                    state_d = StDone;
                end else if (response) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (timeout_hit) begin
                    state_d = StDone;
                end else if (response) begin
                    state_d = last_word ? StDone : StRead;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output and datapath next values; every output leaves a flop
    always_comb begin
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        words_done_d = words_done_q;
        error_d      = error_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        wait_cnt_d   = '0;

        rd_d   = (state_d == StRead);
        wr_d   = (state_d == StWrite);
        busy_d = rd_d || wr_d;
        done_d = (state_d == StDone);

        if (in_request && !response && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + WaitWidth'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d        = src_aligned;
                    dst_d        = dst_aligned;
                    len_d        = len;
                    words_done_d = '0;
                    error_d      = 1'b0;
                    if (len != '0) begin
                        address_d = src_aligned;
                    end
                end
            end
            StRead: begin
                if (timeout_hit) begin
                    error_d = 1'b1;
                end else if (response) begin
                    write_data_d = read_data;
                    address_d    = dst_q;
                end
            end
            StWrite: begin
                if (timeout_hit) begin
                    error_d = 1'b1;
                end else if (response) begin
                    words_done_d = words_inc;
                    src_d        = src_q + 32'd4;
                    dst_d        = dst_q + 32'd4;
                    if (!last_word) begin
                        address_d = src_q + 32'd4;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_done   = words_done_q;
    assign memory_read  = rd_q;
    assign memory_write = wr_q;
    assign address      = address_q;
    assign write_data   = write_data_q;

endmodule
